// File: rtl/mem_dma_pkg.sv
// Shared constants for the mem_dma_initiator copy engine: FSM encoding and bus constants.
// Keeps the alignment rule in one place so the top and any future variants agree.
package mem_dma_pkg;
  localparam int unsigned DW_BYTES  = 8;
  localparam logic [7:0]  WSTRB_ALL = 8'hFF;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RD   = 2'd1;
  localparam logic [1:0] ST_WR   = 2'd2;
  localparam logic [1:0] ST_GAP  = 2'd3;

  // Fill commands never read, so only the destination must be doubleword aligned.
  function automatic logic misaligned(input logic fill, input logic [2:0] src_lo,
                                      input logic [2:0] dst_lo);
    return (dst_lo != 3'd0) || (!fill && (src_lo != 3'd0));
  endfunction
endpackage

// File: rtl/mem_dma_timeout.sv
// Per-transaction wait counter: cleared outside RD/WR, counts cycles without mem_ready.
// expire_o fires combinationally in the wait cycle that brings the count to TIMEOUT.
module mem_dma_timeout #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic resetn,
  input  logic clr_i,
  input  logic inc_i,
  output logic expire_o
);
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!resetn || clr_i) begin
      cnt_q <= '0;
    end else if (inc_i) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign expire_o = inc_i && (cnt_q == CW'(TIMEOUT - 1));
endmodule

// File: rtl/mem_dma_initiator.sv
// Bus-master copy engine (RD, GAP, WR, GAP per doubleword); done/err pulse one cycle after the end.
// Fill mode (WR-only sequence from cmd_pattern) exists only when DMA_FILL_EN is defined.
module mem_dma_initiator #(
  parameter int LEN_W   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [63:0]      cmd_src,
  input  logic [63:0]      cmd_dst,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             cmd_fill,
  input  logic [63:0]      cmd_pattern,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             mem_valid,
  output logic             mem_instr,
  output logic [63:0]      mem_addr,
  output logic [63:0]      mem_wdata,
  output logic [7:0]       mem_wstrb,
  input  logic             mem_ready,
  input  logic [63:0]      mem_rdata
);
  import mem_dma_pkg::*;

  logic [1:0]       state_q, state_d;
  logic [63:0]      src_q, src_d, dst_q, dst_d, data_q, data_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             nxt_wr_q, nxt_wr_d, fill_q, fill_d;
  logic             done_q, done_d, err_q, err_d;
  logic             in_xfer, tmo, acc_fill;

`ifdef DMA_FILL_EN
  assign acc_fill = cmd_fill;
`else
  logic unused_fill;
  assign acc_fill    = 1'b0;
  assign unused_fill = ^{cmd_fill, cmd_pattern};
`endif

  assign in_xfer   = (state_q == ST_RD) || (state_q == ST_WR);
  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign err       = err_q;
  assign mem_valid = in_xfer;
  assign mem_instr = 1'b0;
  assign mem_addr  = (state_q == ST_WR) ? dst_q : src_q;
  assign mem_wdata = data_q;
  assign mem_wstrb = (state_q == ST_WR) ? WSTRB_ALL : 8'h00;

  generate
    if (TIMEOUT > 0) begin : g_tmo
      mem_dma_timeout #(.TIMEOUT(TIMEOUT)) u_tmo (
        .clk      (clk),
        .resetn   (resetn),
        .clr_i    (!in_xfer),
        .inc_i    (in_xfer && !mem_ready),
        .expire_o (tmo)
      );
    end else begin : g_no_tmo
      assign tmo = 1'b0;
    end
  endgenerate

  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    dst_d    = dst_q;
    data_d   = data_q;
    rem_d    = rem_q;
    nxt_wr_d = nxt_wr_q;
    fill_d   = fill_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          fill_d = acc_fill;
          src_d  = cmd_src;
          dst_d  = cmd_dst;
          rem_d  = cmd_len;
`ifdef DMA_FILL_EN
          if (cmd_fill) data_d = cmd_pattern;
`endif
          if (misaligned(acc_fill, cmd_src[2:0], cmd_dst[2:0])) begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end else if (cmd_len == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = acc_fill ? ST_WR : ST_RD;
          end
        end
      end
      ST_RD: begin
        if (tmo) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else if (mem_ready) begin
          data_d   = mem_rdata;
          nxt_wr_d = 1'b1;
          state_d  = ST_GAP;
        end
      end
      ST_WR: begin
        if (tmo) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else if (mem_ready) begin
          src_d = src_q + 64'(DW_BYTES);
          dst_d = dst_q + 64'(DW_BYTES);
          rem_d = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            nxt_wr_d = fill_q;
            state_d  = ST_GAP;
          end
        end
      end
      default: state_d = nxt_wr_q ? ST_WR : ST_RD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      src_q    <= '0;
      dst_q    <= '0;
      data_q   <= '0;
      rem_q    <= '0;
      nxt_wr_q <= 1'b0;
      fill_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      data_q   <= data_d;
      rem_q    <= rem_d;
      nxt_wr_q <= nxt_wr_d;
      fill_q   <= fill_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end
endmodule

// File: tb/tb_mem_dma_initiator.sv
// Bench for mem_dma_initiator: memory responder with random waits plus a list-level copy/fill model.
// Works with and without DMA_FILL_EN; the DUT is built with a 16-cycle timeout.
module tb_mem_dma_initiator;
  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [63:0] cmd_src = '0, cmd_dst = '0, cmd_pattern = '0;
  logic [15:0] cmd_len = '0;
  logic        cmd_fill = 1'b0;
  logic        busy, done, err, mem_valid, mem_instr;
  logic [63:0] mem_addr, mem_wdata;
  logic [7:0]  mem_wstrb;
  logic        mem_ready = 1'b0;
  logic [63:0] mem_rdata = '0;

  mem_dma_initiator #(.LEN_W(16), .TIMEOUT(TMO)) dut (
    .clk(clk), .resetn(resetn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_len(cmd_len), .cmd_fill(cmd_fill),
    .cmd_pattern(cmd_pattern), .busy(busy), .done(done), .err(err),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  strb;
    logic [63:0] addr;
    logic [63:0] data;
  } tx_t;

  tx_t         obs_q[$];
  tx_t         exp_q[$];
  logic [63:0] mem[logic [63:0]];
  logic [63:0] ref_mem[logic [63:0]];
  int n_tests = 0, n_fail = 0;
  int done_cnt = 0, exp_done = 0, stab_err = 0, strb_err = 0;
  bit resp_en = 1'b1, spur_en = 1'b0;
  int max_wait = 0;

  function automatic logic [63:0] defval(input logic [63:0] a);
    return {~a[31:0], a[31:0]} ^ 64'h5A5A_0F0F_1234_8765;
  endfunction

  function automatic logic [63:0] mem_get(input logic [63:0] a);
    return mem.exists(a >> 3) ? mem[a >> 3] : defval(a);
  endfunction

  function automatic logic [63:0] ref_get(input logic [63:0] a);
    return ref_mem.exists(a >> 3) ? ref_mem[a >> 3] : defval(a);
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Memory responder and bus monitor, evaluated mid-cycle.
  initial begin : mon
    logic [63:0] a0, d0;
    logic [7:0]  s0;
    bit in_tx, prev_hs;
    int wcnt, target;
    in_tx = 0; prev_hs = 0; wcnt = 0; target = 0; a0 = '0; d0 = '0; s0 = '0;
    forever begin
      @(negedge clk);
      if (done) done_cnt++;
      if (prev_hs) check("gap_valid_low", 64'(mem_valid), 64'd0);
      if (!mem_valid && mem_wstrb != 8'h00) strb_err++;
      prev_hs = 0;
      if (mem_valid) begin
        if (!in_tx) begin
          in_tx = 1; a0 = mem_addr; d0 = mem_wdata; s0 = mem_wstrb; wcnt = 0;
          target = int'($urandom_range(32'(max_wait)));
        end else if (mem_addr != a0 || mem_wdata != d0 || mem_wstrb != s0) begin
          stab_err++;
        end
        if (resp_en && wcnt >= target) begin
          mem_ready = 1'b1;
          if (mem_wstrb == 8'hFF) begin
            mem[mem_addr >> 3] = mem_wdata;
            obs_q.push_back({mem_wstrb, mem_addr, mem_wdata});
          end else begin
            mem_rdata = mem_get(mem_addr);
            obs_q.push_back({mem_wstrb, mem_addr, mem_rdata});
          end
          prev_hs = 1; in_tx = 0;
        end else begin
          mem_ready = 1'b0;
          wcnt++;
        end
      end else begin
        in_tx = 0;
        mem_ready = spur_en ? 1'($urandom_range(1)) : 1'b0;
        mem_rdata = {$urandom, $urandom};
      end
    end
  end

  task automatic drive_cmd(input logic [63:0] src, input logic [63:0] dst,
                           input logic [15:0] len, input bit fill, input logic [63:0] pat);
    cmd_valid = 1'b1; cmd_src = src; cmd_dst = dst; cmd_len = len;
    cmd_fill = fill; cmd_pattern = pat;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_src = {$urandom, $urandom}; cmd_dst = {$urandom, $urandom};
    cmd_len = 16'($urandom); cmd_fill = 1'($urandom); cmd_pattern = {$urandom, $urandom};
  endtask

  // Called at a negedge with the engine idle; returns at the negedge where done is seen.
  task automatic run_cmd(input logic [63:0] src, input logic [63:0] dst, input logic [15:0] len,
                         input bit fill, input logic [63:0] pat, input int mw);
    bit f, e;
    int k, first_v, budget, exp_lat;
`ifdef DMA_FILL_EN
    f = fill;
`else
    f = 1'b0;
`endif
    e = (dst[2:0] != 3'd0) || (!f && src[2:0] != 3'd0);
    ref_mem = mem;
    exp_q.delete();
    obs_q.delete();
    if (!e) begin
      for (int i = 0; i < int'(len); i++) begin
        logic [63:0] s, d, v;
        s = src + 64'(8 * i);
        d = dst + 64'(8 * i);
        v = f ? pat : ref_get(s);
        if (!f) exp_q.push_back({8'h00, s, v});
        exp_q.push_back({8'hFF, d, v});
        ref_mem[d >> 3] = v;
      end
    end
    max_wait = mw;
    check("cmd_ready_idle", 64'(cmd_ready), 64'd1);
    drive_cmd(src, dst, len, fill, pat);
    exp_done++;
    k = 0; first_v = 0;
    budget = 4 * int'(len) * (mw + 2) + 8;
    while (k < budget) begin
      @(negedge clk);
      k++;
      if (mem_valid && first_v == 0) first_v = k;
      if (done) break;
    end
    check("done_seen", 64'(done), 64'd1);
    check("err", 64'(err), 64'(e));
    check("busy_at_done", 64'(busy), 64'd0);
    check("cmd_ready_at_done", 64'(cmd_ready), 64'd1);
    check("first_valid_cycle", 64'(first_v), (e || len == 0) ? 64'd0 : 64'd1);
    if (mw == 0) begin
      exp_lat = (e || len == 0) ? 1 : (f ? 2 * int'(len) : 4 * int'(len));
      check("latency", 64'(k), 64'(exp_lat));
    end
    check("tx_count", 64'(obs_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      check("tx_strb", 64'(obs_q[i].strb), 64'(exp_q[i].strb));
      check("tx_addr", obs_q[i].addr, exp_q[i].addr);
      check("tx_data", obs_q[i].data, exp_q[i].data);
    end
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int k, nv, nw;
    logic [63:0] s, d;
    repeat (3) @(negedge clk);
    check("rst_mem_valid", 64'(mem_valid), 64'd0);
    check("rst_mem_addr", mem_addr, 64'd0);
    check("rst_mem_wdata", mem_wdata, 64'd0);
    check("rst_mem_wstrb", 64'(mem_wstrb), 64'd0);
    check("rst_mem_instr", 64'(mem_instr), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    resetn = 1'b1;
    @(negedge clk);

    // Basic copy of 4 doublewords with a zero-wait responder.
    run_cmd(64'h100, 64'h800, 16'd4, 1'b0, 64'd0, 0);
    for (int i = 0; i < 4; i++)
      check("copy_mem", mem_get(64'h800 + 64'(8 * i)), mem_get(64'h100 + 64'(8 * i)));
    run_cmd(64'h100, 64'h800, 16'd0, 1'b0, 64'd0, 0);
    run_cmd(64'h100, 64'h804, 16'd3, 1'b0, 64'd0, 0);
    run_cmd(64'h103, 64'h800, 16'd3, 1'b0, 64'd0, 0);
    run_cmd(64'hFFFF_FFFF_FFFF_FFF0, 64'h1000, 16'd4, 1'b0, 64'd0, 0);
    run_cmd(64'h2000, 64'hFFFF_FFFF_FFFF_FFF8, 16'd3, 1'b0, 64'd0, 2);

    // Fill mode: writes only; ignored (plain copy) when the feature is absent.
    run_cmd(64'h5, 64'h200, 16'd3, 1'b1, 64'hDEAD_BEEF_CAFE_F00D, 0);
`ifdef DMA_FILL_EN
    for (int i = 0; i < 3; i++)
      check("fill_mem", mem_get(64'h200 + 64'(8 * i)), 64'hDEAD_BEEF_CAFE_F00D);
`endif

    // Randomized commands, waits and stray mem_ready pulses while idle.
    spur_en = 1'b1;
    for (int n = 0; n < 40; n++) begin
      s = {$urandom, $urandom} & ~64'h7;
      d = {$urandom, $urandom} & ~64'h7;
      if ($urandom_range(7) == 0) s[2:0] = 3'($urandom_range(7));
      if ($urandom_range(7) == 0) d[2:0] = 3'($urandom_range(7));
      run_cmd(s, d, 16'($urandom_range(6)), 1'($urandom_range(1)), {$urandom, $urandom},
              int'($urandom_range(3)));
    end
    spur_en = 1'b0;

    // Responder that never answers.
    resp_en = 1'b0;
    check("to_cmd_ready", 64'(cmd_ready), 64'd1);
    drive_cmd(64'h300, 64'h900, 16'd2, 1'b0, 64'd0);
    exp_done++;
    k = 0; nv = 0;
    while (k < 60) begin
      @(negedge clk);
      k++;
      if (mem_valid) nv++;
      if (done) break;
    end
    check("to_valid_cycles", 64'(nv), 64'(TMO));
    check("to_done", 64'(done), 64'd1);
    check("to_err", 64'(err), 64'd1);
    check("to_busy", 64'(busy), 64'd0);
    check("to_valid_low", 64'(mem_valid), 64'd0);
    resp_en = 1'b1;
    @(negedge clk);

    // Reset during the second write aborts without a done pulse.
    max_wait = 0;
    drive_cmd(64'h400, 64'hA00, 16'd4, 1'b0, 64'd0);
    k = 0; nw = 0;
    while (k < 40) begin
      @(negedge clk);
      k++;
      if (mem_valid && mem_wstrb == 8'hFF) nw++;
      if (nw == 2) break;
    end
    check("rst_reached_wr2", 64'(nw), 64'd2);
    resetn = 1'b0;
    @(negedge clk);
    check("mid_rst_mem_valid", 64'(mem_valid), 64'd0);
    check("mid_rst_mem_addr", mem_addr, 64'd0);
    check("mid_rst_mem_wdata", mem_wdata, 64'd0);
    check("mid_rst_mem_wstrb", 64'(mem_wstrb), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_done", 64'(done), 64'd0);
    check("mid_rst_err", 64'(err), 64'd0);
    check("mid_rst_cmd_ready", 64'(cmd_ready), 64'd1);
    resetn = 1'b1;
    repeat (4) @(negedge clk);
    run_cmd(64'h400, 64'hA00, 16'd4, 1'b0, 64'd0, 1);

    @(negedge clk);
    check("done_pulses", 64'(done_cnt), 64'(exp_done));
    check("bus_stability", 64'(stab_err), 64'd0);
    check("wstrb_idle_zero", 64'(strb_err), 64'd0);
    check("mem_instr", 64'(mem_instr), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_dma_initiator.md
# mem_dma_initiator

Bus-master copy engine for the 64-bit valid/ready memory bus of the picorv_ez test system. It shares the bus role of the CPU: it drives `mem_valid`, `mem_addr`, `mem_wdata` and `mem_wstrb`, and consumes `mem_ready` and `mem_rdata` from the memory responder. A single command copies N doublewords from a source address to a destination address using strictly alternating read and write transactions. The block lets benches and firmware-less tests move memory without the CPU, behind an external arbiter.

## Interface
Parameters:
- `LEN_W`, 16: width of the doubleword count.
- `TIMEOUT`, 1024: maximum cycles to wait for `mem_ready` per transaction. 0 disables the timeout.

Ports:
- `clk` in 1: clock.
- `resetn` in 1: reset, synchronous, active-low.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: high in IDLE only.
- `cmd_src` in 64: source byte address.
- `cmd_dst` in 64: destination byte address.
- `cmd_len` in LEN_W: number of doublewords to copy.
- `cmd_fill` in 1: fill mode select (only with `DMA_FILL_EN`).
- `cmd_pattern` in 64: fill value (only with `DMA_FILL_EN`).
- `busy` out 1: a command is in progress.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: qualifies `done`; set on misalignment or timeout.
- `mem_valid` out 1; `mem_instr` out 1 (tied 0); `mem_addr` out 64; `mem_wdata` out 64; `mem_wstrb` out 8.
- `mem_ready` in 1; `mem_rdata` in 64.

## Operation
- States: IDLE, RD, WR, GAP.
- Command acceptance is `cmd_valid && cmd_ready`. Inputs are latched on acceptance and ignored afterwards.
- Error at acceptance: if `cmd_src[2:0]` or `cmd_dst[2:0]` is nonzero, the block issues no bus traffic. Next cycle `done=1` and `err=1`, and it stays in IDLE.
- Empty command: `cmd_len==0` gives `done=1`, `err=0` the next cycle, with no bus traffic.
- RD state:
  - Drives `mem_valid=1`, `mem_addr=src`, `mem_wstrb=0`.
  - On `mem_ready`, captures `mem_rdata` into the data register and goes to GAP (next op = write).
- WR state:
  - Drives `mem_valid=1`, `mem_addr=dst`, `mem_wdata=data`, `mem_wstrb=8'hFF`.
  - On `mem_ready`: `src+=8`, `dst+=8`, `remaining-=1`.
  - If `remaining` becomes 0: return to IDLE with `done=1`.
  - Otherwise go to GAP (next op = read).
- GAP state: `mem_valid=0` for exactly one cycle, then enter the pending op. The responder requires `mem_valid` low between transactions.
- Bus signal stability: address, wdata and wstrb are held constant while `mem_valid=1`. `mem_wstrb` is 0 whenever `mem_valid=0`.
- Address arithmetic:
  - Addresses are 64-bit and wrap modulo 2^64 without error.
  - `remaining` is LEN_W bits; the maximum `cmd_len` is 2^LEN_W−1.
- Timeout:
  - A counter clears on entering RD/WR and increments each cycle `mem_ready=0`.
  - Reaching `TIMEOUT` drops `mem_valid` and returns to IDLE with `done=1`, `err=1`.
- `busy` is 1 in every state except IDLE.

## Timing
- Reset values:
  - `mem_valid=0`, `mem_addr=0`, `mem_wdata=0`, `mem_wstrb=0`, `mem_instr=0`.
  - `busy=0`, `done=0`, `err=0`, `cmd_ready=1`.
- Reset applied mid-command aborts immediately: no `done` is issued, and the bus returns to idle on the next edge.
- Latency:
  - Acceptance at edge t gives `mem_valid=1` (read) after edge t+1.
  - The cycle after a `mem_ready` is always the GAP cycle.
  - Per doubleword with zero-wait responder: RD(1+w) + GAP(1) + WR(1+w) + GAP(1).
- `done` asserts the cycle after the final write's `mem_ready` and coincides with `cmd_ready` returning to 1.
- A new command may be accepted in the same cycle `done` is high.
- `mem_ready` while `mem_valid=0` is ignored.

## Configuration
- `DMA_FILL_EN` defined:
  - `cmd_fill=1` skips all RD states. `data=cmd_pattern`.
  - The sequence is WR, GAP, WR…; only `cmd_dst[2:0]` is checked for alignment.
- `DMA_FILL_EN` undefined: `cmd_fill` and `cmd_pattern` are ignored (the ports remain, unused). Only copy mode exists.

## Structure
- Package `mem_dma_pkg`: state enum, `DW_BYTES=8`, `WSTRB_ALL=8'hFF`.
- One sub-module, `mem_dma_timeout`: the per-transaction wait counter with a clear input and an expiry output. It is bypassed when `TIMEOUT==0`.

## Test plan
- Copy 4 doublewords `src=0x100`→`dst=0x800` against the memory responder model:
  - Expect 8 transactions in the order R,W,R,W…, each followed by a 1-cycle `mem_valid` low gap.
  - Memory at 0x800..0x818 equals 0x100..0x118.
  - `done=1`, `err=0`.
- `cmd_len=0`: `done` asserts 1 cycle after acceptance, `mem_valid` never asserts.
- Misaligned `cmd_dst=0x804`: `done=1`, `err=1` next cycle, no bus traffic.
- Responder that never asserts `mem_ready`, `TIMEOUT=16`: `mem_valid` drops after 16 wait cycles, then `done=1`, `err=1`, `busy=0`.
- `resetn` low during the second WR: all outputs at reset values the next cycle, no `done` pulse, a new command is accepted afterwards.
- With `DMA_FILL_EN`, fill 3 doublewords `dst=0x200`, `pattern=0xDEADBEEF_CAFEF00D`:
  - Exactly 3 writes with `wstrb=0xFF`, no reads.
  - Memory holds the pattern at 0x200, 0x208, 0x210.
